serial_comparator: RTL and testbench

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

---
 rtl/serial_comparator_pkg.sv | 24 ++
 rtl/serial_comparator_digit_compare.sv | 16 +
 rtl/serial_comparator.sv | 117 +++++++++++
 tb/tb_serial_comparator.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_comparator_pkg.sv
// Shared constants for serial_comparator: FSM state encoding and the
// one-hot {equal, greater, less} result encoding.
package serial_comparator_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t COMPARE = 2'd1;
    localparam state_t DONE    = 2'd2;

    // Result vector bit order is {equal, greater, less}.
    typedef logic [2:0] result_t;

    localparam result_t RES_NONE = 3'b000;
    localparam result_t RES_EQ   = 3'b100;
    localparam result_t RES_GT   = 3'b010;
    localparam result_t RES_LT   = 3'b001;

    // Counter width for n digits; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_comparator_digit_compare.sv
// Combinational compare of one DIGIT-bit slice: eq when equal, gt when a > b.
module digit_compare #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             eq,
    output logic             gt
);

    always_comb begin
        eq = (a == b);
        gt = (a > b);
    end

endmodule

// File: rtl/serial_comparator.sv
// Digit-serial magnitude comparator, MSB digit first with early exit.
// Define CMP_SIGNED_EN to add the signed_mode port for two's-complement compares.
module serial_comparator
    import serial_comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             greater,
    output logic             less
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_comparator: WIDTH must be >= 2");
    end
    if ((DIGIT == 0) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
        $error("serial_comparator: WIDTH must be an integer multiple of DIGIT");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    result_t          res_q, res_d;
    logic [WIDTH-1:0] msb_flip;
    logic             dig_eq;
    logic             dig_gt;

`ifdef CMP_SIGNED_EN
    // Inverting both MSBs maps two's-complement order onto unsigned order.
    assign msb_flip = signed_mode ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
`else
    assign msb_flip = '0;
`endif

    digit_compare #(
        .DIGIT (DIGIT)
    ) u_digit_compare (
        .a  (a_q[WIDTH-1 -: DIGIT]),
        .b  (b_q[WIDTH-1 -: DIGIT]),
        .eq (dig_eq),
        .gt (dig_gt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a ^ msb_flip;
                    b_d     = b ^ msb_flip;
                    cnt_d   = '0;
                    res_d   = RES_NONE;
                    state_d = COMPARE;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            COMPARE: begin
                if (!dig_eq) begin
                    res_d   = dig_gt ? RES_GT : RES_LT;
                    state_d = DONE;
                end else if (cnt_q == LAST) begin
                    res_d   = RES_EQ;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    a_d   = a_q << DIGIT;
                    b_d   = b_q << DIGIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= RES_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        busy                    = (state_q == COMPARE);
        done                    = (state_q == DONE);
        {equal, greater, less}  = res_q;
    end

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator (WIDTH=16, DIGIT=4) with a result scoreboard.
module tb_serial_comparator;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DIGIT = 4;
    localparam int unsigned N     = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             signed_mode = 1'b0;
    logic             busy, done, equal, greater, less;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0] res;
        int         lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    serial_comparator #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
`ifdef CMP_SIGNED_EN
        .signed_mode (signed_mode),
`endif
        .busy        (busy),
        .done        (done),
        .equal       (equal),
        .greater     (greater),
        .less        (less)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result from native compares; latency from the first differing MSB-first digit.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic sm);
        exp_t e;
        bit   found = 0;
        if (sm) begin
            e.res = {($signed(x) == $signed(y)), ($signed(x) > $signed(y)),
                     ($signed(x) < $signed(y))};
        end else begin
            e.res = {(x == y), (x > y), (x < y)};
        end
        e.lat = N;
        for (int i = 0; i < int'(N); i++) begin
            if (!found && (x[WIDTH-1-i*DIGIT -: DIGIT] != y[WIDTH-1-i*DIGIT -: DIGIT])) begin
                e.lat = i + 1;
                found = 1;
            end
        end
        return e;
    endfunction

    task automatic run_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic sm, input int inject_at, input string tag);
        exp_t e;
        int   cyc = 0;
        int   busy_cnt = 1;
        bit   seen = 0;
        bit   injected;
        @(negedge clk);
        a = x;
        b = y;
        signed_mode = sm;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back(model(x, y, sm));
        check({tag, "/clear"}, {29'd0, equal, greater, less}, 32'd0);
        check({tag, "/busy_on"}, {31'd0, busy}, 32'd1);
        while (!seen && cyc < int'(4 * N)) begin
            injected = 0;
            if (cyc == inject_at) begin
                a = '1;
                b = '0;
                start = 1'b1;
                injected = 1;
            end
            @(posedge clk);
            #1;
            if (injected) start = 1'b0;
            cyc++;
            if (done) seen = 1;
            else if (busy) busy_cnt++;
        end
        e = sb.pop_front();
        check({tag, "/done"}, {31'd0, seen}, 32'd1);
        check({tag, "/latency"}, cyc, e.lat);
        check({tag, "/result"}, {29'd0, equal, greater, less}, {29'd0, e.res});
        check({tag, "/busy_cycles"}, busy_cnt, e.lat);
        check({tag, "/busy_off"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic hold_check(input string tag, input logic [2:0] res);
        repeat (2) begin
            @(posedge clk);
            #1;
            check({tag, "/done_pulse"}, {31'd0, done}, 32'd0);
            check({tag, "/held"}, {29'd0, equal, greater, less}, {29'd0, res});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("reset/busy", {31'd0, busy}, 32'd0);
        check("reset/done", {31'd0, done}, 32'd0);
        check("reset/result", {29'd0, equal, greater, less}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_cmp(16'h1234, 16'h1234, 1'b0, -1, "equal");
        hold_check("equal", 3'b100);

        run_cmp(16'h8000, 16'h7FFF, 1'b0, -1, "msb_unsigned");
        hold_check("msb_unsigned", 3'b010);
`ifdef CMP_SIGNED_EN
        run_cmp(16'h8000, 16'h7FFF, 1'b1, -1, "msb_signed");
        hold_check("msb_signed", 3'b001);
        run_cmp(16'hFFFF, 16'h0001, 1'b1, -1, "neg_vs_pos");
`endif

        run_cmp(16'h00F0, 16'h00F1, 1'b0, -1, "lsb_less");
        hold_check("lsb_less", 3'b001);

        run_cmp(16'h00F0, 16'h00F1, 1'b0, 2, "ignore_start");
        hold_check("ignore_start", 3'b001);

        // Abort a long compare with reset.
        @(negedge clk);
        a = 16'h1234;
        b = 16'h1234;
        signed_mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back(model(16'h1234, 16'h1234, 1'b0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort/busy", {31'd0, busy}, 32'd0);
        check("abort/done", {31'd0, done}, 32'd0);
        check("abort/result", {29'd0, equal, greater, less}, 32'd0);
        sb.delete();
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort/no_done", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_cmp(16'h0001, 16'h0000, 1'b0, -1, "post_reset");

        // Back-to-back: next start lands in the DONE cycle.
        repeat (2) @(posedge clk);
        run_cmp(16'h5A00, 16'h5B00, 1'b0, -1, "b2b_first");
        check("b2b/in_done", {31'd0, done}, 32'd1);
        run_cmp(16'h0003, 16'h0002, 1'b0, -1, "b2b_second");
        hold_check("b2b_second", 3'b010);

        for (int i = 0; i < 6; i++) begin
            logic [WIDTH-1:0] rx;
            logic [WIDTH-1:0] ry;
            rx = WIDTH'($urandom);
            ry = (i % 2 == 0) ? (rx ^ WIDTH'(1 << $urandom_range(WIDTH - 1, 0)))
                              : WIDTH'($urandom);
            repeat (2) @(posedge clk);
            run_cmp(rx, ry, 1'b0, -1, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
